hist_report_tx: RTL and testbench

HIST_REPORT_TX -- requirements
Module: hist_report_tx

---
 rtl/hist_pkg.sv | 30 +++
 rtl/hist_frame_buf.sv | 28 ++
 rtl/hist_report_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_hist_report_tx.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hist_pkg.sv
// Shared FSM state type and report framing constants for hist_report_tx.
// HIST_REPORT_CHECKSUM_EN adds a trailing XOR checksum byte to every report.
package hist_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StSendHdr,
    StSendFrame,
    StSendSort
`ifdef HIST_REPORT_CHECKSUM_EN
    , StSendChk
`endif
  } state_e;

  localparam logic [7:0]  HdrByte   = 8'hA5;
  localparam int unsigned HdrBytes  = 1;
  localparam int unsigned SortBytes = 6;
`ifdef HIST_REPORT_CHECKSUM_EN
  localparam int unsigned ChkBytes  = 1;
`else
  localparam int unsigned ChkBytes  = 0;
`endif

  // Total bytes in one report for a frame of the given sample count.
  function automatic int unsigned report_len(input int unsigned length);
    return HdrBytes + length / 2 + SortBytes + ChkBytes;
  endfunction

endpackage

// File: rtl/hist_frame_buf.sv
// Frame sample store: one write port, one combinational read port that returns
// the sample pair (2k, 2k+1) for pair index k.
module hist_frame_buf #(
  parameter int unsigned DataSize = 4,
  parameter int unsigned Length   = 64,
  parameter int unsigned AddrSize = 6
) (
  input  logic                clk_i,
  input  logic                wr_en_i,
  input  logic [AddrSize-1:0] wr_addr_i,
  input  logic [DataSize-1:0] wr_data_i,
  input  logic [AddrSize-2:0] rd_pair_i,
  output logic [DataSize-1:0] rd_even_o,
  output logic [DataSize-1:0] rd_odd_o
);

  logic [DataSize-1:0] mem_q [Length];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_even_o = mem_q[{rd_pair_i, 1'b0}];
  assign rd_odd_o  = mem_q[{rd_pair_i, 1'b1}];

endmodule

// File: rtl/hist_report_tx.sv
// Captures one frame plus the top-3 histogram result and streams them out as a
// byte report. HIST_REPORT_CHECKSUM_EN appends an XOR checksum byte.
module hist_report_tx
  import hist_pkg::*;
#(
  parameter int unsigned DATA_SIZE   = 4,
  parameter int unsigned LENGTH      = 64,
  parameter int unsigned LENGTH_SIZE = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   FramEn,
  input  logic [LENGTH_SIZE-1:0] FramAdd,
  input  logic [DATA_SIZE-1:0]   FramData,
  input  logic                   SortValid,
  input  logic [DATA_SIZE-1:0]   MaxCountData1,
  input  logic [DATA_SIZE-1:0]   MaxCountData2,
  input  logic [DATA_SIZE-1:0]   MaxCountData3,
  input  logic [LENGTH_SIZE-1:0] MaxCount1,
  input  logic [LENGTH_SIZE-1:0] MaxCount2,
  input  logic [LENGTH_SIZE-1:0] MaxCount3,
  output logic                   TxValid,
  output logic [7:0]             TxData,
  output logic                   TxLast,
  input  logic                   TxReady,
  output logic                   FrameErr,
  output logic                   Overrun
);

  localparam logic [LENGTH_SIZE-1:0] FrameLast  = LENGTH_SIZE'(LENGTH / 2 - 1);
  localparam logic [LENGTH_SIZE-1:0] SortLast   = LENGTH_SIZE'(SortBytes - 1);
  localparam logic [LENGTH_SIZE-1:0] SampleLast = LENGTH_SIZE'(LENGTH - 1);

  state_e                 state_q, state_d;
  logic [LENGTH_SIZE-1:0] exp_addr_q, exp_addr_d;
  logic                   done_q, done_d;
  logic [LENGTH_SIZE-1:0] idx_q, idx_d;
  logic                   sort_ok_q, sort_ok_d;
  logic [DATA_SIZE-1:0]   mcd_q [3];
  logic [DATA_SIZE-1:0]   mcd_d [3];
  logic [LENGTH_SIZE-1:0] mc_q [3];
  logic [LENGTH_SIZE-1:0] mc_d [3];
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef HIST_REPORT_CHECKSUM_EN
  logic [7:0]             chk_q, chk_d;
`endif

  logic                 in_send, xfer, frame_start, wr_en, last_wr, addr_err, sort_latch;
  logic [DATA_SIZE-1:0] rd_even, rd_odd;
  logic [7:0]           sort_byte;

  assign in_send     = (state_q == StSendHdr) || (state_q == StSendFrame) ||
                       (state_q == StSendSort)
`ifdef HIST_REPORT_CHECKSUM_EN
                       || (state_q == StSendChk)
`endif
                       ;
  assign xfer        = TxValid && TxReady;
  assign frame_start = (state_q == StIdle) && FramEn && (FramAdd == '0);
  assign wr_en       = frame_start ||
                       ((state_q == StCapture) && FramEn && !done_q && (FramAdd == exp_addr_q));
  assign last_wr     = (state_q == StCapture) && wr_en && (FramAdd == SampleLast);
  // Once the frame is complete any further sample is out of sequence.
  assign addr_err    = (state_q == StCapture) && FramEn && (done_q || (FramAdd != exp_addr_q));
  assign sort_latch  = SortValid && ((state_q == StIdle) || (state_q == StCapture));

  hist_frame_buf #(
    .DataSize (DATA_SIZE),
    .Length   (LENGTH),
    .AddrSize (LENGTH_SIZE)
  ) u_frame_buf (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (FramAdd),
    .wr_data_i (FramData),
    .rd_pair_i (idx_q[LENGTH_SIZE-2:0]),
    .rd_even_o (rd_even),
    .rd_odd_o  (rd_odd)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:      if (frame_start) state_d = StCapture;
      StCapture: begin
        if (addr_err) begin
          state_d = StIdle;
        end else if ((last_wr || done_q) && (sort_ok_q || SortValid)) begin
          state_d = StSendHdr;
        end
      end
      StSendHdr:   if (xfer) state_d = StSendFrame;
      StSendFrame: if (xfer && (idx_q == FrameLast)) state_d = StSendSort;
`ifdef HIST_REPORT_CHECKSUM_EN
      StSendSort:  if (xfer && (idx_q == SortLast)) state_d = StSendChk;
      StSendChk:   if (xfer) state_d = StIdle;
`else
      StSendSort:  if (xfer && (idx_q == SortLast)) state_d = StIdle;
`endif
      default:     state_d = StIdle;
    endcase
  end

  always_comb begin
    case (idx_q[2:0])
      3'd0:    sort_byte = 8'(mcd_q[0]);
      3'd1:    sort_byte = 8'(mc_q[0]);
      3'd2:    sort_byte = 8'(mcd_q[1]);
      3'd3:    sort_byte = 8'(mc_q[1]);
      3'd4:    sort_byte = 8'(mcd_q[2]);
      default: sort_byte = 8'(mc_q[2]);
    endcase
  end

  // Output logic: the byte on offer is a pure function of state and index, so it
  // holds steady for as long as the sink stalls.
  always_comb begin
    TxValid = in_send;
    TxData  = '0;
    TxLast  = 1'b0;
    case (state_q)
      StSendHdr:   TxData = HdrByte;
      StSendFrame: TxData = {4'(rd_odd), 4'(rd_even)};
      StSendSort: begin
        TxData = sort_byte;
`ifndef HIST_REPORT_CHECKSUM_EN
        TxLast = (idx_q == SortLast);
`endif
      end
`ifdef HIST_REPORT_CHECKSUM_EN
      StSendChk: begin
        TxData = chk_q;
        TxLast = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    exp_addr_d  = exp_addr_q;
    done_d      = done_q;
    idx_d       = idx_q;
    sort_ok_d   = sort_ok_q;
    mcd_d       = mcd_q;
    mc_d        = mc_q;
    frame_err_d = frame_err_q | addr_err;
    overrun_d   = overrun_q | (in_send && FramEn);

    if (frame_start) begin
      exp_addr_d = LENGTH_SIZE'(1);
    end else if (addr_err) begin
      exp_addr_d = '0;
    end else if (wr_en) begin
      exp_addr_d = exp_addr_q + LENGTH_SIZE'(1);
    end

    if (state_q == StIdle) done_d = 1'b0;
    if (last_wr) done_d = 1'b1;

    // Index restarts whenever the byte stream moves into a new section.
    if (xfer) begin
      idx_d = (state_d != state_q) ? '0 : idx_q + LENGTH_SIZE'(1);
    end

    if (sort_latch) begin
      sort_ok_d = 1'b1;
      mcd_d     = '{MaxCountData1, MaxCountData2, MaxCountData3};
      mc_d      = '{MaxCount1, MaxCount2, MaxCount3};
    end
    if (xfer && TxLast) sort_ok_d = 1'b0;
  end

`ifdef HIST_REPORT_CHECKSUM_EN
  always_comb begin
    chk_d = chk_q;
    if (state_q == StIdle) chk_d = '0;
    else if (xfer) chk_d = chk_q ^ TxData;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_addr_q  <= '0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      sort_ok_q   <= 1'b0;
      mcd_q       <= '{default: '0};
      mc_q        <= '{default: '0};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      exp_addr_q  <= exp_addr_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      sort_ok_q   <= sort_ok_d;
      mcd_q       <= mcd_d;
      mc_q        <= mc_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef HIST_REPORT_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end
`endif

  assign FrameErr = frame_err_q;
  assign Overrun  = overrun_q;

endmodule

// File: tb/tb_hist_report_tx.sv
// Scoreboard bench for hist_report_tx: stimulus queues expected report bytes,
// a negedge monitor pops and compares each transferred byte.
module tb_hist_report_tx;
  import hist_pkg::*;

  localparam int unsigned DS     = 4;
  localparam int unsigned LEN    = 64;
  localparam int unsigned LS     = 6;
  localparam int unsigned RptLen = report_len(LEN);

  logic          clk = 1'b0;
  logic          rst;
  logic          FramEn;
  logic [LS-1:0] FramAdd;
  logic [DS-1:0] FramData;
  logic          SortValid;
  logic [DS-1:0] MaxCountData1, MaxCountData2, MaxCountData3;
  logic [LS-1:0] MaxCount1, MaxCount2, MaxCount3;
  logic          TxValid;
  logic [7:0]    TxData;
  logic          TxLast;
  logic          TxReady;
  logic          FrameErr;
  logic          Overrun;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] fb [LEN];

  always #5 clk = ~clk;

  hist_report_tx #(
    .DATA_SIZE   (DS),
    .LENGTH      (LEN),
    .LENGTH_SIZE (LS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .FramEn        (FramEn),
    .FramAdd       (FramAdd),
    .FramData      (FramData),
    .SortValid     (SortValid),
    .MaxCountData1 (MaxCountData1),
    .MaxCountData2 (MaxCountData2),
    .MaxCountData3 (MaxCountData3),
    .MaxCount1     (MaxCount1),
    .MaxCount2     (MaxCount2),
    .MaxCount3     (MaxCount3),
    .TxValid       (TxValid),
    .TxData        (TxData),
    .TxLast        (TxLast),
    .TxReady       (TxReady),
    .FrameErr      (FrameErr),
    .Overrun       (Overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: compares transferred bytes and checks hold-stability under stall.
  initial begin
    bit         stall = 1'b0;
    logic [7:0] held_data;
    logic       held_last;
    int         rx_idx = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall  = 1'b0;
        rx_idx = 0;
      end else if (!TxValid) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_data", TxData, held_data);
          check("stall_last", TxLast, held_last);
        end
        if (TxReady) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no transfer", TxData);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d_data", rx_idx + 1), TxData, e.data);
            check($sformatf("byte%0d_last", rx_idx + 1), TxLast, e.last);
            rx_idx = e.last ? 0 : rx_idx + 1;
          end
          stall = 1'b0;
        end else begin
          stall     = 1'b1;
          held_data = TxData;
          held_last = TxLast;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // pat 0: ramp addr[3:0]; pat 1: 15-addr[3:0]; pat 2: constant 7.
  task automatic drive_frame(input int pat, input bit model);
    logic [3:0] d;
    for (int a = 0; a < LEN; a++) begin
      d        = (pat == 0) ? 4'(a) : (pat == 1) ? 4'(15 - (a % 16)) : 4'h7;
      FramEn   = 1'b1;
      FramAdd  = LS'(a);
      FramData = d;
      if (model) fb[a] = d;
      tick();
    end
    FramEn   = 1'b0;
    FramAdd  = '0;
    FramData = '0;
  endtask

  task automatic pulse_sort(input int d1, input int c1, input int d2, input int c2,
                            input int d3, input int c3);
    MaxCountData1 = DS'(d1);
    MaxCount1     = LS'(c1);
    MaxCountData2 = DS'(d2);
    MaxCount2     = LS'(c2);
    MaxCountData3 = DS'(d3);
    MaxCount3     = LS'(c3);
    SortValid     = 1'b1;
    tick();
    SortValid     = 1'b0;
  endtask

  task automatic push_report(input int d1, input int c1, input int d2, input int c2,
                             input int d3, input int c3);
    logic [7:0] b[$];
    exp_t       e;
    b.push_back(8'hA5);
    for (int k = 0; k < LEN / 2; k++) b.push_back({fb[2*k+1], fb[2*k]});
    b.push_back(8'(d1));
    b.push_back(8'(c1));
    b.push_back(8'(d2));
    b.push_back(8'(c2));
    b.push_back(8'(d3));
    b.push_back(8'(c3));
`ifdef HIST_REPORT_CHECKSUM_EN
    begin
      logic [7:0] x = 8'h00;
      foreach (b[i]) x ^= b[i];
      b.push_back(x);
    end
`endif
    foreach (b[i]) begin
      e.data = b[i];
      e.last = (i == b.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  // pattern 0: TxReady always 1; pattern 1: 1,0,0 repeating.
  task automatic run_tx(input int pattern, input int budget);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      TxReady = (pattern == 0) ? 1'b1 : ((cyc % 3) == 0);
      tick();
      cyc++;
    end
    check("report_drained", exp_q.size(), 0);
    tick();
    check("idle_after_report", TxValid, 1'b0);
  endtask

  initial begin
    int stalls;
    int hits;
    rst = 1'b1;
    FramEn = 1'b0;
    FramAdd = '0;
    FramData = '0;
    SortValid = 1'b0;
    MaxCountData1 = '0;
    MaxCountData2 = '0;
    MaxCountData3 = '0;
    MaxCount1 = '0;
    MaxCount2 = '0;
    MaxCount3 = '0;
    TxReady = 1'b0;
    repeat (3) tick();
    check("rst_txvalid", TxValid, 1'b0);
    check("rst_txlast", TxLast, 1'b0);
    check("rst_txdata", TxData, 8'h00);
    check("rst_frameerr", FrameErr, 1'b0);
    check("rst_overrun", Overrun, 1'b0);
    rst = 1'b0;
    tick();

    // Ramp frame, SortValid five cycles later, sink always ready.
    TxReady = 1'b1;
    drive_frame(0, 1'b1);
    push_report(5, 20, 3, 18, 9, 7);
    for (int i = 0; i < 5; i++) check("wait_sort_novalid", TxValid, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    pulse_sort(5, 20, 3, 18, 9, 7);
    check("first_valid_after_sort", TxValid, 1'b1);
    run_tx(0, 200);

    // Sort result first, then frame, sink toggling 1,0,0.
    TxReady = 1'b0;
    pulse_sort(1, 2, 3, 4, 15, 63);
    drive_frame(0, 1'b1);
    push_report(1, 2, 3, 4, 15, 63);
    run_tx(1, 400);

    // Address skip aborts the frame; a clean frame afterwards still reports.
    TxReady = 1'b1;
    FramEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      FramAdd  = (i == 3) ? LS'(4) : LS'(i);
      FramData = 4'(i + 3);
      tick();
    end
    FramEn = 1'b0;
    check("skip_frameerr", FrameErr, 1'b1);
    check("skip_state_idle", 32'(dut.state_q), 32'(StIdle));
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (TxValid) hits++;
    end
    check("skip_no_txvalid", hits, 0);
    drive_frame(1, 1'b1);
    push_report(7, 33, 0, 1, 12, 40);
    pulse_sort(7, 33, 0, 1, 12, 40);
    run_tx(0, 200);
    check("frameerr_sticky", FrameErr, 1'b1);
    check("overrun_still_clear", Overrun, 1'b0);

    // Second frame while stalled in SEND_FRAME.
    pulse_sort(2, 10, 4, 11, 6, 12);
    drive_frame(0, 1'b1);
    push_report(2, 10, 4, 11, 6, 12);
    for (int i = 0; i < 4; i++) tick();
    TxReady = 1'b0;
    check("stalled_in_frame", 32'(dut.state_q), 32'(StSendFrame));
    drive_frame(2, 1'b0);
    check("overrun_set", Overrun, 1'b1);
    run_tx(0, 200);
    check("overrun_sticky", Overrun, 1'b1);

    // Reset while byte 10 is stalled.
    pulse_sort(8, 9, 10, 11, 12, 13);
    drive_frame(1, 1'b1);
    push_report(8, 9, 10, 11, 12, 13);
    stalls = 0;
    while (exp_q.size() != RptLen - 9 && stalls < 50) begin
      TxReady = 1'b1;
      tick();
      stalls++;
    end
    check("reached_byte10", exp_q.size(), RptLen - 9);
    TxReady = 1'b0;
    tick();
    check("byte10_held_valid", TxValid, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_mid_txvalid", TxValid, 1'b0);
    check("rst_mid_txlast", TxLast, 1'b0);
    exp_q.delete();
    rst = 1'b0;
    check("rst_mid_frameerr", FrameErr, 1'b0);
    check("rst_mid_overrun", Overrun, 1'b0);
    TxReady = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (TxValid) hits++;
    end
    check("no_resume_after_rst", hits, 0);
    pulse_sort(3, 3, 2, 2, 1, 1);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (TxValid) hits++;
    end
    check("sort_alone_no_report", hits, 0);
    drive_frame(0, 1'b1);
    push_report(3, 3, 2, 2, 1, 1);
    run_tx(0, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
